// File: rtl/sc_port_arbiter.sv
// sc_port_arbiter: slow-control frame sequencer and reply router.
// Latches the target slave per frame, then forwards its reply or an error.
module sc_port_arbiter #(
  parameter int                 NSLV        = 4,
  parameter logic [16*NSLV-1:0] PORT_LIST   = {16'h1779, 16'h1788,
                                               16'h1787, 16'h1777},
  parameter int                 TIMEOUT     = 1024,
  parameter logic [31:0]        ERR_NOPORT  = 32'h00000001,
  parameter logic [31:0]        ERR_TIMEOUT = 32'h00000002
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [15:0]          sc_port,
  input  logic                 sc_frame,
  input  logic                 sc_op,
  input  logic [NSLV-1:0]      slv_ack,
  input  logic [32*NSLV-1:0]   slv_rply_data,
  input  logic [32*NSLV-1:0]   slv_rply_error,
  output logic                 sc_ack,
  output logic [31:0]          sc_rply_data,
  output logic [31:0]          sc_rply_error,
  output logic [NSLV-1:0]      slv_sel,
  output logic                 busy,
  output logic [15:0]          timeout_cnt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FRAME,
    S_WAIT
  } state_t;

  localparam logic [15:0] LastCnt = 16'(TIMEOUT - 1);

  state_t            r_state;
  logic              r_nomatch;
  logic [15:0]       r_wcnt;

  logic [NSLV-1:0]   w_dec_sel;
  logic              w_dec_hit;
  logic              w_ack;
  logic [31:0]       w_data;
  logic [31:0]       w_err;

  // Scan downwards so the lowest matching index overrides the others.
  always_comb begin
    w_dec_sel = '0;
    w_dec_hit = 1'b0;
    for (int i = NSLV - 1; i >= 0; i--) begin
      if (PORT_LIST[16*i +: 16] == sc_port) begin
        w_dec_sel    = '0;
        w_dec_sel[i] = 1'b1;
        w_dec_hit    = 1'b1;
      end
    end
  end

  always_comb begin
    w_data = '0;
    w_err  = '0;
    for (int i = 0; i < NSLV; i++) begin
      if (slv_sel[i]) begin
        w_data = slv_rply_data[32*i +: 32];
        w_err  = slv_rply_error[32*i +: 32];
      end
    end
  end

  assign w_ack = |(slv_ack & slv_sel);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_nomatch     <= 1'b0;
      r_wcnt        <= '0;
      sc_ack        <= 1'b0;
      sc_rply_data  <= '0;
      sc_rply_error <= '0;
      slv_sel       <= '0;
      busy          <= 1'b0;
      timeout_cnt   <= '0;
    end else begin
      sc_ack <= 1'b0;
      if (!sc_frame) begin
        // Frame abort: drop any transaction without replying.
        r_state   <= S_IDLE;
        r_nomatch <= 1'b0;
        r_wcnt    <= '0;
        slv_sel   <= '0;
        busy      <= 1'b0;
      end else begin
        unique case (r_state)
          S_IDLE: begin
            slv_sel   <= w_dec_sel;
            r_nomatch <= !w_dec_hit;
            r_state   <= S_FRAME;
          end
          S_FRAME: begin
            if (sc_op) begin
              r_state <= S_WAIT;
              busy    <= 1'b1;
              r_wcnt  <= '0;
            end
          end
          S_WAIT: begin
            if (r_nomatch) begin
              sc_ack        <= 1'b1;
              sc_rply_data  <= '0;
              sc_rply_error <= ERR_NOPORT;
              busy          <= 1'b0;
              r_state       <= S_FRAME;
            end else if (w_ack) begin
              sc_ack        <= 1'b1;
              sc_rply_data  <= w_data;
              sc_rply_error <= w_err;
              busy          <= 1'b0;
              r_state       <= S_FRAME;
            end else if (r_wcnt == LastCnt) begin
              sc_ack        <= 1'b1;
              sc_rply_data  <= '0;
              sc_rply_error <= ERR_TIMEOUT;
              busy          <= 1'b0;
              r_state       <= S_FRAME;
              if (timeout_cnt != 16'hFFFF) begin
                timeout_cnt <= timeout_cnt + 16'd1;
              end
            end else begin
              r_wcnt <= r_wcnt + 16'd1;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
